pixel_fetch_pipe: RTL and testbench

//  Pixel stage downstream of the scaled address mapper. Owns per-frame scroll offsets: latches requested

---
 rtl/pixel_pkg.sv | 35 +++
 rtl/palette_ram.sv | 58 +++++
 rtl/pixel_fetch_pipe.sv | 194 +++++++++++++++++++
 tb/tb_pixel_fetch_pipe.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel fetch pipeline.
//  - rgb_t / pal_idx_t : default-width colour and palette index types
//  - sideband_t        : per-pixel control bits that travel beside the ROM fetch
//  - pipe_lat()        : end-to-end latency in enabled cycles for a given ROM latency
//  - sideband_idle()   : blank sideband value (not displayed, syncs inactive)
package pixel_pkg;

  localparam int CWIDTH_DEF = 12;
  localparam int DWIDTH_DEF = 4;

  typedef logic [CWIDTH_DEF-1:0] rgb_t;
  typedef logic [DWIDTH_DEF-1:0] pal_idx_t;

  typedef struct packed {
    logic active;  // display enable
    logic valid;   // mapper in-bounds flag
    logic hs;      // horizontal sync
    logic vs;      // vertical sync
  } sideband_t;

  // Address register + ROM latency + palette/colour register.
  function automatic int pipe_lat(input int rom_lat);
    return rom_lat + 2;
  endfunction

  function automatic sideband_t sideband_idle(input logic sync_idle);
    sideband_t s;
    s.active = 1'b0;
    s.valid  = 1'b0;
    s.hs     = sync_idle;
    s.vs     = sync_idle;
    return s;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Palette register file: 2**DWIDTH entries of CWIDTH-bit colour.
// One write port (always active) and one registered read port gated by re.
// A read and a write of the same entry on the same clock return the old entry.
// Ports:
//  clk, rst_n      clock, asynchronous active-low reset (clears contents)
//  we/waddr/wdata  write strobe, index, colour
//  re/raddr        read enable (pipeline advance) and index
//  rdata           registered read data
module palette_ram
  import pixel_pkg::*;
#(
  parameter int DWIDTH = 4,
  parameter int CWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DWIDTH-1:0] waddr,
  input  logic [CWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [DWIDTH-1:0] raddr,
  output logic [CWIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << DWIDTH;

  logic [CWIDTH-1:0] mem_q [DEPTH];
  logic [CWIDTH-1:0] mem_d [DEPTH];
  logic [CWIDTH-1:0] rd_q;
  logic [CWIDTH-1:0] rd_d;

  // Read samples mem_q (pre-write contents), which gives read-before-write.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
    if (re) begin
      rd_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rdata = rd_q;

endmodule

// File: rtl/pixel_fetch_pipe.sv
// Pixel stage behind the scaled address mapper.
//  - Latches scroll offset requests at frame start (hdata==0, vdata==0, pix_ce)
//    and drives them to the mapper; frame_start pulses for one clk on each latch.
//  - Registers the mapper address as rom_addr, carries {active, valid, hs, vs}
//    alongside through the ROM latency, then reads the palette with the returned
//    index and selects the output colour (blank / background / palette).
//  - hsync_out/vsync_out leave the pipe aligned with rgb, LAT = ROM_LAT+2 enabled
//    cycles after hdata/vdata.
// Ports:
//  clk, rst_n, pix_ce                      clock, async active-low reset, pixel enable
//  hdata, vdata, active, hsync_in, vsync_in raster timing in
//  hoffset_req, voffset_req                requested signed scroll
//  hoffset, voffset                        latched scroll to mapper
//  map_addr, map_valid                     mapper result
//  rom_addr, rom_data                      sprite-ROM interface
//  bg_color                                background for transparent / out-of-bounds
//  pal_we, pal_waddr, pal_wdata            palette write port
//  rgb, hsync_out, vsync_out, frame_start  outputs
module pixel_fetch_pipe
  import pixel_pkg::*;
#(
  parameter int   HWIDTH     = 12,
  parameter int   VWIDTH     = 12,
  parameter int   AWIDTH     = 15,
  parameter int   DWIDTH     = 4,
  parameter int   CWIDTH     = 12,
  parameter int   ROM_LAT    = 1,
  parameter int   TRANSP_IDX = 0,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  input  logic [HWIDTH-1:0] hdata,
  input  logic [VWIDTH-1:0] vdata,
  input  logic              active,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [HWIDTH-1:0] hoffset_req,
  input  logic [VWIDTH-1:0] voffset_req,
  output logic [HWIDTH-1:0] hoffset,
  output logic [VWIDTH-1:0] voffset,
  input  logic [AWIDTH-1:0] map_addr,
  input  logic              map_valid,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_data,
  input  logic [CWIDTH-1:0] bg_color,
  input  logic              pal_we,
  input  logic [DWIDTH-1:0] pal_waddr,
  input  logic [CWIDTH-1:0] pal_wdata,
  output logic [CWIDTH-1:0] rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_start
);

  localparam int LAT = pipe_lat(ROM_LAT);

  // ---------------------------------------------------------------------------
  // Frame-start offset latch
  // ---------------------------------------------------------------------------
  logic              frame_hit;
  logic [HWIDTH-1:0] hoffset_q, hoffset_d;
  logic [VWIDTH-1:0] voffset_q, voffset_d;
  logic              frame_start_q, frame_start_d;

  assign frame_hit = pix_ce && (hdata == '0) && (vdata == '0);

  always_comb begin
    hoffset_d     = hoffset_q;
    voffset_d     = voffset_q;
    // Pulse is recomputed every clk so it drops even while pix_ce is low.
    frame_start_d = frame_hit;
    if (frame_hit) begin
      hoffset_d = hoffset_req;
      voffset_d = voffset_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hoffset_q     <= '0;
      voffset_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hoffset_q     <= hoffset_d;
      voffset_q     <= voffset_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hoffset     = hoffset_q;
  assign voffset     = voffset_q;
  assign frame_start = frame_start_q;

  // ---------------------------------------------------------------------------
  // S1: ROM address register
  // ---------------------------------------------------------------------------
  logic [AWIDTH-1:0] rom_addr_q, rom_addr_d;

  assign rom_addr_d = pix_ce ? map_addr : rom_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
    end
  end

  assign rom_addr = rom_addr_q;

  // ---------------------------------------------------------------------------
  // Sideband delay line. Stage 0 loads with rom_addr, stages 1..ROM_LAT wait
  // out the ROM, stage LAT-1 loads together with the palette read.
  // ---------------------------------------------------------------------------
  sideband_t sb_q [LAT];
  sideband_t sb_d [LAT];
  sideband_t sb_in;

  assign sb_in.active = active;
  assign sb_in.valid  = map_valid;
  assign sb_in.hs     = hsync_in;
  assign sb_in.vs     = vsync_in;

  for (genvar gi = 0; gi < LAT; gi++) begin : g_sb
    if (gi == 0) begin : g_head
      assign sb_d[gi] = pix_ce ? sb_in : sb_q[gi];
    end else begin : g_tail
      assign sb_d[gi] = pix_ce ? sb_q[gi-1] : sb_q[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sb_q[gi] <= sideband_idle(SYNC_IDLE);
      end else begin
        sb_q[gi] <= sb_d[gi];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: palette read plus the index/background captured on the same edge, so
  // the colour mux below only sees registered values and holds with pix_ce=0.
  // ---------------------------------------------------------------------------
  logic [CWIDTH-1:0] pal_rdata;
  logic [DWIDTH-1:0] idx_q, idx_d;
  logic [CWIDTH-1:0] bg_q, bg_d;

  palette_ram #(
    .DWIDTH (DWIDTH),
    .CWIDTH (CWIDTH)
  ) u_palette (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (pal_we),
    .waddr (pal_waddr),
    .wdata (pal_wdata),
    .re    (pix_ce),
    .raddr (rom_data),
    .rdata (pal_rdata)
  );

  assign idx_d = pix_ce ? rom_data : idx_q;
  assign bg_d  = pix_ce ? bg_color : bg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      bg_q  <= '0;
    end else begin
      idx_q <= idx_d;
      bg_q  <= bg_d;
    end
  end

  sideband_t sb_out;
  assign sb_out = sb_q[LAT-1];

  always_comb begin
    rgb = '0;
    if (sb_out.active) begin
      if (!sb_out.valid || (idx_q == DWIDTH'(TRANSP_IDX))) begin
        rgb = bg_q;
      end else begin
        rgb = pal_rdata;
      end
    end
  end

  assign hsync_out = sb_out.hs;
  assign vsync_out = sb_out.vs;

endmodule

// File: tb/tb_pixel_fetch_pipe.sv
module tb_pixel_fetch_pipe;
  import pixel_pkg::*;

  localparam int H_TOT = 16;
  localparam int V_TOT = 5;
  localparam int N_CYC = 2400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_ce;
  logic [11:0] hdata, vdata;
  logic        active, hsync_in, vsync_in;
  logic [11:0] hoffset_req, voffset_req;
  logic [11:0] hoffset, voffset;
  logic [14:0] map_addr;
  logic        map_valid;
  logic [14:0] rom_addr;
  logic [3:0]  rom_data;
  rgb_t        bg_color;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  rgb_t        pal_wdata;
  rgb_t        rgb;
  logic        hsync_out, vsync_out, frame_start;

  always #5 clk = ~clk;

  pixel_fetch_pipe dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .hdata(hdata), .vdata(vdata),
    .active(active), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hoffset_req(hoffset_req), .voffset_req(voffset_req),
    .hoffset(hoffset), .voffset(voffset), .map_addr(map_addr), .map_valid(map_valid),
    .rom_addr(rom_addr), .rom_data(rom_data), .bg_color(bg_color),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_start(frame_start)
  );

  // Sprite ROM: fixed content, one enabled cycle of latency.
  function automatic logic [3:0] rom_fn(input logic [14:0] a);
    return a[3:0] ^ a[11:8];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rom_data <= 4'd0;
    else if (pix_ce) rom_data <= rom_fn(rom_addr);
  end

  // ---------------------------------------------------------------------------
  // Reference model: each enabled pixel enters a queue; the third enabled edge
  // after entry is when it is shown, using the palette as it stood before that
  // edge's write and the background present at that edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       act;
    logic       vld;
    logic       hs;
    logic       vs;
    logic [3:0] idx;
  } pix_t;

  pix_t        hist[$];
  rgb_t        pal_m [16];
  rgb_t        exp_rgb;
  logic        exp_hs, exp_vs, exp_fs;
  logic [11:0] exp_hoff, exp_voff;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_frames = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 16; i++) pal_m[i] = '0;
    exp_rgb  = '0;
    exp_hs   = 1'b1;
    exp_vs   = 1'b1;
    exp_fs   = 1'b0;
    exp_hoff = '0;
    exp_voff = '0;
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic step();
    pix_t p;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_fs = pix_ce && (hdata == 0) && (vdata == 0);
      if (exp_fs) begin
        exp_hoff = hoffset_req;
        exp_voff = voffset_req;
        n_frames++;
        $display("frame %0d: offsets latched h=%0d v=%0d", n_frames,
                 $signed(hoffset_req), $signed(voffset_req));
      end
      if (pix_ce) begin
        p.act = active; p.vld = map_valid; p.hs = hsync_in; p.vs = vsync_in;
        p.idx = rom_fn(map_addr);
        hist.push_back(p);
        if (hist.size() == 3) begin
          p = hist.pop_front();
          if (!p.act) exp_rgb = '0;
          else if (!p.vld || p.idx == 4'd0) exp_rgb = bg_color;
          else exp_rgb = pal_m[p.idx];
          exp_hs = p.hs;
          exp_vs = p.vs;
        end
      end
      if (pal_we) pal_m[pal_waddr] = pal_wdata;
    end
    #1;
    check("rgb", 32'(rgb), 32'(exp_rgb));
    check("hsync_out", 32'(hsync_out), 32'(exp_hs));
    check("vsync_out", 32'(vsync_out), 32'(exp_vs));
    check("hoffset", 32'(hoffset), 32'(exp_hoff));
    check("voffset", 32'(voffset), 32'(exp_voff));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
  endtask

  int h_cnt = 0, v_cnt = 0;

  task automatic drive_raster();
    hdata    = 12'(h_cnt);
    vdata    = 12'(v_cnt);
    active   = (h_cnt < 10) && (v_cnt < 4);
    hsync_in = !((h_cnt >= 11) && (h_cnt <= 12));
    vsync_in = (v_cnt != 4);
  endtask

  initial begin
    logic ce_prev;
    rst_n = 1'b0; pix_ce = 1'b0; hoffset_req = 12'd3; voffset_req = 12'd1;
    map_addr = '0; map_valid = 1'b1; bg_color = 12'h0AF;
    pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
    drive_raster();
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;

    // Fill the palette with pix_ce low: outputs must stay at reset values.
    for (int i = 0; i < 16; i++) begin
      pal_we = 1'b1;
      pal_waddr = 4'(i);
      pal_wdata = (i == 5) ? 12'hF00 : 12'($urandom);
      step();
    end
    pal_we = 1'b0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      // Mid-line asynchronous reset between clock edges.
      if (cyc == 1900) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_hsync", 32'(hsync_out), 32'h1);
        check("rst_vsync", 32'(vsync_out), 32'h1);
        check("rst_hoffset", 32'(hoffset), 32'h0);
        check("rst_voffset", 32'(voffset), 32'h0);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        model_reset();
      end
      if (cyc == 1903) rst_n = 1'b1;

      if (cyc < 600)       pix_ce = 1'b1;
      else if (cyc < 1400) pix_ce = (cyc % 4 == 0);
      else                 pix_ce = 1'($urandom_range(0, 1));

      map_addr  = 15'($urandom);
      map_valid = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 31) == 0) bg_color = 12'($urandom);
      if (cyc == 50) hoffset_req = 12'hFF8;
      else if ($urandom_range(0, 7) == 0) hoffset_req = 12'($urandom);
      if ($urandom_range(0, 7) == 0) voffset_req = 12'($urandom);

      pal_we = ($urandom_range(0, 7) == 0);
      // Half the writes hit the entry about to be read, exercising read-before-write.
      pal_waddr = $urandom_range(0, 1) ? rom_data : 4'($urandom);
      pal_wdata = 12'($urandom);

      ce_prev = pix_ce;
      step();
      if (ce_prev) begin
        h_cnt = (h_cnt == H_TOT - 1) ? 0 : h_cnt + 1;
        if (h_cnt == 0) v_cnt = (v_cnt == V_TOT - 1) ? 0 : v_cnt + 1;
      end
      drive_raster();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
